// File: rtl/fdivsqrt_iter_ctrl_pkg.sv
// Shared types for the fdivsqrt sequencer: config record, state enum, C mask init helper.
package fdivsqrt_iter_ctrl_pkg;

  typedef struct packed {
    int DIVb;
    int DURLEN;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{DIVb: 12, DURLEN: 4};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fdivsqrt_state_t;

  // Initial digit mask: two integer ones above DIVb fraction zeros (U2.DIVb).
  function automatic logic [63:0] cinit(input int divb);
    return 64'd3 << divb;
  endfunction

endpackage

// File: rtl/fdivsqrt_cmask.sv
// Digit-position mask register for the OTFC; shifts ones in from the top by SHIFT per step.
module fdivsqrt_cmask #(
  parameter int             W     = 14,
  parameter int             SHIFT = 2,
  parameter logic [W-1:0]   CINIT = '0
) (
  input  logic         clk,
  input  logic         init,
  input  logic         shift,
  output logic [W-1:0] C
);

  logic [W-1:0] c_reg;

  // init doubles as the synchronous reset; once all-ones the shift is a no-op.
  always_ff @(posedge clk) begin
    if (init)
      c_reg <= CINIT;
    else if (shift)
      c_reg <= {{SHIFT{1'b1}}, c_reg[W-1:SHIFT]};
  end

  assign C = c_reg;

endmodule

// File: rtl/fdivsqrt_iter_ctrl.sv
// Radix-4 divide/sqrt iteration sequencer: start, N iteration cycles, then done handshake.
module fdivsqrt_iter_ctrl
  import fdivsqrt_iter_ctrl_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FlushE,
  input  logic                Start,
  input  logic                SpecialCase,
  input  logic [P.DURLEN-1:0] Cycles,
  input  logic                StallM,
  output logic                Busy,
  output logic                InitEn,
  output logic                IterEn,
  output logic                LastIter,
  output logic                Done,
  output logic [P.DIVb+1:0]   C
);

  localparam int              CW         = P.DIVb + 2;
  localparam logic [63:0]     CINIT_WIDE = cinit(P.DIVb);
  localparam logic [CW-1:0]   CINIT      = CINIT_WIDE[CW-1:0];

  fdivsqrt_state_t     state_reg;
  logic [P.DURLEN-1:0] cnt_reg;
  logic                kill;
  logic                accept;
  logic                instant;

  assign kill    = reset | FlushE;
  assign instant = SpecialCase | (Cycles == '0);
  assign accept  = (state_reg == IDLE) & Start & ~kill;

  assign InitEn   = accept;
  assign Busy     = (state_reg != IDLE);
  assign IterEn   = (state_reg == BUSY) & ~kill;
  assign LastIter = IterEn & (cnt_reg == '0);
  assign Done     = (state_reg == DONE) & ~kill;

  always_ff @(posedge clk) begin
    if (kill) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            if (instant) begin
              state_reg <= DONE;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= Cycles - 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == '0) state_reg <= DONE;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        DONE: begin
          if (!StallM) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Special-case starts leave the mask untouched; only real runs reload it.
  fdivsqrt_cmask #(
    .W     (CW),
    .SHIFT (2),
    .CINIT (CINIT)
  ) u_cmask (
    .clk   (clk),
    .init  (kill | (accept & ~instant)),
    .shift ((state_reg == BUSY) & ~kill),
    .C     (C)
  );

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Self-checking bench: operation-level reference model checked every cycle, plus directed literal checks.
module tb_fdivsqrt_iter_ctrl;
  import fdivsqrt_iter_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        FlushE = 1'b0;
  logic        Start = 1'b0;
  logic        SpecialCase = 1'b0;
  logic [3:0]  Cycles = 4'd0;
  logic        StallM = 1'b0;
  logic        Busy, InitEn, IterEn, LastIter, Done;
  logic [13:0] C;

  int errors = 0;
  int checks = 0;

  // Model: iterations still to run, waiting-for-accept flag, iterations since last mask load.
  int m_iter_left = 0;
  bit m_done      = 1'b0;
  int m_k         = 0;

  always #5 clk = ~clk;

  fdivsqrt_iter_ctrl #(.P(CVW_DEFAULT)) dut (
    .clk         (clk),
    .reset       (reset),
    .FlushE      (FlushE),
    .Start       (Start),
    .SpecialCase (SpecialCase),
    .Cycles      (Cycles),
    .StallM      (StallM),
    .Busy        (Busy),
    .InitEn      (InitEn),
    .IterEn      (IterEn),
    .LastIter    (LastIter),
    .Done        (Done),
    .C           (C)
  );

  function automatic logic [13:0] mask_after(input int k);
    int bits;
    int v;
    bits = 2 * k + 2;
    if (bits > 14) bits = 14;
    v = ((1 << bits) - 1) << (14 - bits);
    return v[13:0];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input bit r, input bit f, input bit s, input bit sp,
                      input logic [3:0] cy, input bit st);
    bit kill, idle;
    @(posedge clk);
    #1;
    reset = r; FlushE = f; Start = s; SpecialCase = sp; Cycles = cy; StallM = st;
    @(negedge clk);
    kill = r | f;
    idle = (m_iter_left == 0) && !m_done;
    chk("Busy",     {15'd0, Busy},     {15'd0, !idle});
    chk("InitEn",   {15'd0, InitEn},   {15'd0, idle && s && !kill});
    chk("IterEn",   {15'd0, IterEn},   {15'd0, (m_iter_left > 0) && !kill});
    chk("LastIter", {15'd0, LastIter}, {15'd0, (m_iter_left == 1) && !kill});
    chk("Done",     {15'd0, Done},     {15'd0, m_done && !kill});
    chk("C",        {2'd0, C},         {2'd0, mask_after(m_k)});
    $display("cyc t=%0t r=%0b f=%0b s=%0b sp=%0b cy=%0d st=%0b | busy=%0b init=%0b iter=%0b last=%0b done=%0b C=%h",
             $time, r, f, s, sp, cy, st, Busy, InitEn, IterEn, LastIter, Done, C);
    if (kill) begin
      m_iter_left = 0; m_done = 1'b0; m_k = 0;
    end else if (m_iter_left > 0) begin
      m_k++;
      m_iter_left--;
      if (m_iter_left == 0) m_done = 1'b1;
    end else if (m_done) begin
      if (!st) m_done = 1'b0;
    end else if (s) begin
      if (sp || cy == 4'd0) m_done = 1'b1;
      else begin
        m_iter_left = int'(cy); m_k = 0;
      end
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_busy", {15'd0, Busy}, 16'd0);
    chk("rst_C", {2'd0, C}, 16'h3000);

    // Normal run, Cycles=3
    step(0, 0, 1, 0, 3, 0);
    chk("n_init", {15'd0, InitEn}, 16'd1);
    step(0, 0, 0, 0, 0, 0); chk("n_C1", {2'd0, C}, 16'h3000); chk("n_it1", {15'd0, IterEn}, 16'd1);
    step(0, 0, 0, 0, 0, 0); chk("n_C2", {2'd0, C}, 16'h3C00);
    step(0, 0, 0, 0, 0, 0); chk("n_C3", {2'd0, C}, 16'h3F00); chk("n_last", {15'd0, LastIter}, 16'd1);
    step(0, 0, 0, 0, 0, 0); chk("n_done", {15'd0, Done}, 16'd1); chk("n_C4", {2'd0, C}, 16'h3FC0);
    step(0, 0, 0, 0, 0, 0); chk("n_idle", {15'd0, Busy}, 16'd0);

    // Special case: Done next cycle, C unchanged
    step(0, 0, 1, 1, 7, 0); chk("sp_init", {15'd0, InitEn}, 16'd1);
    step(0, 0, 0, 0, 0, 0); chk("sp_done", {15'd0, Done}, 16'd1); chk("sp_C", {2'd0, C}, 16'h3FC0);
    step(0, 0, 0, 0, 0, 0);

    // Stall hold, Cycles=2
    step(0, 0, 1, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 3; i <= 5; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("st_done", {15'd0, Done}, 16'd1); chk("st_C", {2'd0, C}, 16'h3F00);
    end
    step(0, 0, 0, 0, 0, 0); chk("st_done6", {15'd0, Done}, 16'd1);
    step(0, 0, 0, 0, 0, 0); chk("st_idle7", {15'd0, Busy}, 16'd0);

    // Flush in BUSY, then immediate restart
    step(0, 0, 1, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0); chk("fl_iter", {15'd0, IterEn}, 16'd0);
    step(0, 0, 1, 0, 5, 0); chk("fl_busy", {15'd0, Busy}, 16'd0); chk("fl_C", {2'd0, C}, 16'h3000);
    chk("fl_restart", {15'd0, InitEn}, 16'd1);
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // Max Cycles=15: saturating mask, no counter wrap
    step(0, 0, 1, 0, 15, 0);
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (IterEn) n++;
      if (i == 7) chk("mx_sat", {2'd0, C}, 16'h3FFF);
      if (i == 16) begin
        chk("mx_done", {15'd0, Done}, 16'd1); chk("mx_C", {2'd0, C}, 16'h3FFF);
      end
    end
    chk("mx_count", n[15:0], 16'd15);
    step(0, 0, 0, 0, 0, 0);

    // Reset mid-BUSY, then FlushE & Start together in IDLE
    step(0, 0, 1, 0, 4, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 4, 0); chk("rb_iter", {15'd0, IterEn}, 16'd0);
    step(0, 1, 1, 0, 4, 0); chk("rb_busy", {15'd0, Busy}, 16'd0); chk("rb_C", {2'd0, C}, 16'h3000);
    chk("fs_init", {15'd0, InitEn}, 16'd0);
    step(0, 0, 0, 0, 0, 0); chk("fs_busy", {15'd0, Busy}, 16'd0); chk("fs_done", {15'd0, Done}, 16'd0);

    // Flush in DONE while stalled drops Done
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1); chk("c1_last", {15'd0, LastIter}, 16'd1);
    step(0, 0, 0, 0, 0, 1); chk("fd_done", {15'd0, Done}, 16'd1);
    step(0, 1, 0, 0, 0, 1); chk("fd_drop", {15'd0, Done}, 16'd0);
    step(0, 0, 0, 0, 0, 1); chk("fd_idle", {15'd0, Busy}, 16'd0);

    // Start held high across DONE is accepted on the following IDLE cycle
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0); chk("sh_ignored", {15'd0, InitEn}, 16'd0);
    step(0, 0, 1, 0, 1, 0); chk("sh_done", {15'd0, Done}, 16'd1);
    step(0, 0, 1, 0, 1, 0); chk("sh_accept", {15'd0, InitEn}, 16'd1);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 6) == 0,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
